sda_result_buffer: RTL and testbench

- Downstream stage of six_digit_adder: captures each 6-bit two's-complement sum and its carry-out, and computes signed overflow.
- Buffers results in a small FIFO with valid/ready handshakes on both sides.
- Keeps a saturating count of overflow events for status readout.

---
 rtl/sda_pkg.sv | 22 ++
 rtl/sda_fifo_mem.sv | 33 +++
 rtl/sda_result_buffer.sv | 99 +++++++++
 tb/tb_sda_result_buffer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sda_pkg.sv
// sda_pkg: shared definitions for the six_digit_adder result path.
//   SDA_WIDTH            default operand/sum width of six_digit_adder
//   ENT_*                field offsets of a buffered result entry
//   sda_ovf()            signed-overflow detect from operand/result sign bits
package sda_pkg;

    localparam int SDA_WIDTH   = 6;

    // Entry layout: {ovf, cout, sum[WIDTH-1:0]}
    localparam int ENT_SUM_LSB = 0;
    localparam int ENT_COUT    = SDA_WIDTH;
    localparam int ENT_OVF     = SDA_WIDTH + 1;
    localparam int ENT_W       = SDA_WIDTH + 2;

    // Two's-complement add overflows only when both operands share a sign
    // and the result sign differs from it.
    function automatic logic sda_ovf(input logic a_msb, input logic b_msb,
                                     input logic sum_msb);
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/sda_fifo_mem.sv
// sda_fifo_mem: DEPTH x ENT_W register array, cleared on reset.
//   clk, rst_n   clock, asynchronous active-low reset (clears all entries)
//   wr_en        write wr_data at wr_addr on the rising edge
//   rd_addr      asynchronous read address; rd_data follows combinationally
module sda_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int ENT_W = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [ENT_W-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [ENT_W-1:0] rd_data
);

    logic [ENT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sda_result_buffer.sv
// sda_result_buffer: captures six_digit_adder results into a small FIFO,
// tagging each with a signed-overflow flag and counting overflow events.
//   in_valid/in_ready    upstream handshake; in_a_msb/in_b_msb operand signs,
//                        in_sum/in_cout adder result
//   out_valid/out_ready  downstream handshake; out_sum/out_cout/out_ovf head entry
//   ovf_count            saturating count of accepted overflowed results
//   level                occupancy 0..DEPTH
module sda_result_buffer
    import sda_pkg::*;
#(
    parameter int WIDTH = SDA_WIDTH,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_a_msb,
    input  logic                     in_b_msb,
    input  logic [WIDTH-1:0]         in_sum,
    input  logic                     in_cout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic                     out_cout,
    output logic                     out_ovf,
    output logic [CNT_W-1:0]         ovf_count,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    // Entry offsets follow the package layout but track this instance's WIDTH.
    localparam int EN_COUT = WIDTH;
    localparam int EN_OVF  = WIDTH + 1;
    localparam int EN_W    = WIDTH + 2;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   lvl;
    logic            push;
    logic            pop;
    logic            ovf;
    logic [EN_W-1:0] wr_ent;
    logic [EN_W-1:0] rd_ent;

    assign in_ready  = (lvl != FULL);
    assign out_valid = (lvl != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign ovf       = sda_ovf(in_a_msb, in_b_msb, in_sum[WIDTH-1]);
    assign wr_ent    = {ovf, in_cout, in_sum};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lvl       <= '0;
            ovf_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                lvl <= lvl + 1'b1;
            end else if (pop && !push) begin
                lvl <= lvl - 1'b1;
            end
            if (push && ovf && (ovf_count != '1)) begin
                ovf_count <= ovf_count + 1'b1;
            end
        end
    end

    sda_fifo_mem #(
        .DEPTH (DEPTH),
        .ENT_W (EN_W),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_ent),
        .rd_addr (rd_ptr),
        .rd_data (rd_ent)
    );

    assign out_sum  = rd_ent[WIDTH-1:ENT_SUM_LSB];
    assign out_cout = rd_ent[EN_COUT];
    assign out_ovf  = rd_ent[EN_OVF];
    assign level    = lvl;

endmodule

// File: tb/tb_sda_result_buffer.sv
module tb_sda_result_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_a_msb, in_b_msb, in_cout, out_ready;
    logic [5:0] in_sum;

    logic       in_ready, out_valid, out_cout, out_ovf;
    logic [5:0] out_sum;
    logic [7:0] ovf_count;
    logic [2:0] level;

    logic       in_ready2, out_valid2, out_cout2, out_ovf2;
    logic [5:0] out_sum2;
    logic [1:0] ovf_count2;
    logic [2:0] level2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q[$];   // reference FIFO of {ovf, cout, sum}
    int cnt;            // reference overflow count, CNT_W=8
    int cnt2;           // reference overflow count, CNT_W=2

    always #5 clk = ~clk;

    sda_result_buffer #(.WIDTH(6), .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
        .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .ovf_count(ovf_count), .level(level)
    );

    sda_result_buffer #(.WIDTH(6), .DEPTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
        .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_sum(out_sum2), .out_cout(out_cout2), .out_ovf(out_ovf2),
        .ovf_count(ovf_count2), .level(level2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("level",      32'(level), 32'(q.size()));
        chk("in_ready",   32'(in_ready), 32'(q.size() != 4));
        chk("out_valid",  32'(out_valid), 32'(q.size() != 0));
        chk("ovf_count",  32'(ovf_count), 32'(cnt));
        chk("ovf_count2", 32'(ovf_count2), 32'(cnt2));
        if (q.size() != 0) begin
            chk("out_sum",  32'(out_sum),  32'(q[0][5:0]));
            chk("out_cout", 32'(out_cout), 32'(q[0][6]));
            chk("out_ovf",  32'(out_ovf),  32'(q[0][7]));
        end
    endtask

    task automatic check_cleared();
        chk("rst_level",     32'(level), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_ovf_count", 32'(ovf_count), 32'd0);
        chk("rst_out_sum",   32'(out_sum), 32'd0);
        chk("rst_out_cout",  32'(out_cout), 32'd0);
        chk("rst_out_ovf",   32'(out_ovf), 32'd0);
    endtask

    // One cycle: present an addition a+b (or idle) and a consumer ready.
    task automatic step(input logic v, input logic [5:0] a, input logic [5:0] b,
                        input logic rdy);
        int         s;
        logic [6:0] u;
        logic       ovf, push, pop;
        u   = {1'b0, a} + {1'b0, b};
        s   = int'($signed(a)) + int'($signed(b));
        ovf = (s > 31) || (s < -32);
        in_valid  = v;
        in_a_msb  = a[5];
        in_b_msb  = b[5];
        in_sum    = u[5:0];
        in_cout   = u[6];
        out_ready = rdy;
        push = v && (q.size() != 4);
        pop  = rdy && (q.size() != 0);
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back({ovf, u[6], u[5:0]});
            if (ovf) begin
                if (cnt < 255) cnt++;
                if (cnt2 < 3) cnt2++;
            end
        end
        check_state();
    endtask

    task automatic model_reset();
        q.delete();
        cnt  = 0;
        cnt2 = 0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a_msb = 1'b0; in_b_msb = 1'b0;
        in_sum = '0; in_cout = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_cleared();
        step(1'b0, 6'd0, 6'd0, 1'b0);

        // -2+2 then -7+2, then drain
        step(1'b1, 6'b111110, 6'd2, 1'b0);
        step(1'b1, 6'b111001, 6'd2, 1'b0);
        chk("head_sum0",  32'(out_sum), 32'h00);
        chk("head_cout0", 32'(out_cout), 32'd1);
        step(1'b0, 6'd0, 6'd0, 1'b1);
        chk("head_sum1",  32'(out_sum), 32'h3b);
        chk("head_cout1", 32'(out_cout), 32'd0);
        step(1'b0, 6'd0, 6'd0, 1'b1);

        // 31+1 and -32+-1 overflow
        step(1'b1, 6'd31, 6'd1, 1'b0);
        step(1'b1, 6'b100000, 6'b111111, 1'b0);
        chk("ovf_two", 32'(ovf_count), 32'd2);
        step(1'b0, 6'd0, 6'd0, 1'b1);
        step(1'b0, 6'd0, 6'd0, 1'b1);

        // Fill with consumer stalled; 5th push must be dropped
        for (int i = 1; i <= 5; i++) step(1'b1, 6'(i), 6'd0, 1'b0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 6'd0, 6'd0, 1'b1);

        // Level 2, then concurrent push/pop across pointer wrap
        step(1'b1, 6'd10, 6'd0, 1'b0);
        step(1'b1, 6'd11, 6'd0, 1'b0);
        for (int i = 12; i < 22; i++) step(1'b1, 6'(i), 6'd0, 1'b1);
        chk("steady_level", 32'(level), 32'd2);
        step(1'b0, 6'd0, 6'd0, 1'b1);
        step(1'b0, 6'd0, 6'd0, 1'b1);

        // Saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) step(1'b1, 6'd31, 6'd1, 1'b1);
        chk("sat_count2", 32'(ovf_count2), 32'd3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 6'($urandom), 6'($urandom),
                 1'($urandom_range(0, 2) != 0));
        end

        // Make sure the buffer holds data, then reset between clock edges
        step(1'b1, 6'd3, 6'd4, 1'b0);
        step(1'b1, 6'd31, 6'd31, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_cleared();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 6'd5, 6'd6, 1'b0);
        step(1'b0, 6'd0, 6'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
